uart_pkt_deframer: RTL and testbench
====================================

UART_PKT_DEFRAMER -- requirements
Module: uart_pkt_deframer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, largest legal payload length in bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 20000, inter-byte timeout in clocks (used only when timeout is compiled in).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  one-cycle strobe from the UART receiver marking a new byte.
REQ-007 SHALL have port in_data  input  8  received byte; sampled only when in_valid=1.
REQ-008 SHALL have port out_valid  output  1  payload byte available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-010 SHALL have port out_data  output  8  payload byte.
REQ-011 SHALL have port out_last  output  1  high with the final payload byte of a packet.
REQ-012 SHALL have port pkt_ok  output  1  one-cycle pulse when a packet passes the checksum check.
REQ-013 SHALL have port pkt_err  output  1  one-cycle pulse on bad length, bad checksum or timeout.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when an input byte is dropped during DRAIN.

Function
REQ-015 SHALL parse frames of the form SYNC_BYTE, LEN, LEN payload bytes, CSUM.
REQ-016 SHALL implement states IDLE, LEN, PAYLOAD, CSUM, DRAIN; all transitions occur only on in_valid, error, timeout or output handshake.
REQ-017 SHALL, in IDLE, discard non-SYNC bytes and move to LEN on in_valid with in_data==SYNC_BYTE.
REQ-018 SHALL, in LEN, accept LEN in 1..MAX_LEN and move to PAYLOAD; LEN==0 or LEN>MAX_LEN pulses pkt_err and returns to IDLE.
REQ-019 SHALL store payload bytes in an internal MAX_LEN x 8 buffer at index 0..LEN-1, moving to CSUM after byte LEN-1.
REQ-020 SHALL accumulate an 8-bit running sum, modulo 256, of LEN and all payload bytes; the frame is valid when (sum + CSUM) mod 256 == 0.
REQ-021 SHALL, in CSUM, on a valid checksum pulse pkt_ok the next cycle and enter DRAIN; on mismatch pulse pkt_err and return to IDLE, discarding the buffer.
REQ-022 SHALL, in DRAIN, present buffer bytes in order with out_valid=1, advancing on out_valid&&out_ready, and assert out_last on index LEN-1.
REQ-023 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL return to IDLE in the cycle after the out_last handshake, with out_valid=0 from that cycle.
REQ-025 SHALL, in DRAIN, including the cycle of the final handshake, drop any in_valid byte and pulse overrun the next cycle.
REQ-026 SHALL keep out_valid=0 in all states except DRAIN.
REQ-027 SHALL register pkt_ok, pkt_err and overrun outputs, each high for exactly one cycle per event.

Reset
REQ-028 SHALL, when resetn=0 at a rising edge, enter IDLE and clear the byte index, running sum and timeout counter.
REQ-029 SHALL drive out_valid=0, out_last=0, pkt_ok=0, pkt_err=0, overrun=0 and out_data=8'h00 in the cycle after reset.
REQ-030 SHALL, on reset mid-packet or mid-drain, abandon the packet without a pkt_err pulse; buffer contents need not be cleared.

Configuration
REQ-031 SHALL, when macro UART_PKT_DEFRAMER_TIMEOUT_EN is defined, count clocks since the last in_valid in LEN, PAYLOAD and CSUM, and on reaching TIMEOUT_CLKS pulse pkt_err and return to IDLE.
REQ-032 SHALL, without UART_PKT_DEFRAMER_TIMEOUT_EN, omit the timeout counter entirely and wait indefinitely in LEN, PAYLOAD and CSUM.

Verification
REQ-033 SHALL cover: A5 03 11 22 33 97 with out_ready=1 -> pkt_ok pulse; out bytes 11, 22, 33; out_last on 33.
REQ-034 SHALL cover: A5 03 11 22 33 98 -> pkt_err pulse; out_valid never asserted.
REQ-035 SHALL cover: A5 00, and separately A5 11 with MAX_LEN=16 -> pkt_err after the LEN byte; state IDLE.
REQ-036 SHALL cover: valid 1-byte frame A5 01 7F 80 with out_ready=0 for 10 cycles -> out_data=7F held stable; byte 55 injected in DRAIN -> overrun pulse; 7F still delivered.
REQ-037 SHALL cover, with the timeout compiled in and TIMEOUT_CLKS=100: A5 02 44 then silence -> pkt_err after 100 clocks; a following valid frame is accepted.
REQ-038 SHALL cover: resetn=0 after A5 02 44 -> all outputs zero; next frame A5 01 10 EF -> pkt_ok, out byte 10.

Source files
------------

// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: parses SYNC, LEN, payload, CSUM frames from a UART byte
// stream, checks the additive checksum and replays the stored payload on a
// valid/ready output. Define UART_PKT_DEFRAMER_TIMEOUT_EN to compile in the
// inter-byte timeout; without it the parser waits indefinitely.
module uart_pkt_deframer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 20000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       overrun
);

    localparam int unsigned IDXW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_bad_param
        $error("uart_pkt_deframer: MAX_LEN must be 1..255 and TIMEOUT_CLKS nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;
    logic       ovr_q, ovr_d;
    logic       buf_we;
    logic [7:0] buf_q [MAX_LEN];

`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Next-state, datapath and pulse decode for the frame parser.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        sum_d   = sum_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        buf_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (in_valid) begin
                    if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = in_data;
                        sum_d   = in_data;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + in_data;
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_CSUM: begin
                if (in_valid) begin
                    if (8'(sum_q + in_data) == 8'd0) begin
                        ok_d    = 1'b1;
                        idx_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // Input bytes cannot be parsed while the buffer is replayed.
                ovr_d = in_valid;
                if (out_ready) begin
                    if (idx_q == len_q - 8'd1) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
        // Timeout overrides the parse result only in cycles with no input byte.
        tmo_d = '0;
        if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) begin
            if (!in_valid) begin
                if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        end
`endif
    end

    // State, index, checksum and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
    // Clocks elapsed since the last input byte while a frame is open.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Payload buffer; contents are only observed in DRAIN so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q[IDXW-1:0]] <= in_data;
        end
    end

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? buf_q[idx_q[IDXW-1:0]] : 8'h00;
    assign out_last  = out_valid && (idx_q == len_q - 8'd1);
    assign pkt_ok    = ok_q;
    assign pkt_err   = err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer. Inputs change 1 ns after the rising
// edge; a negedge monitor collects handshaken bytes and pulse counts.
module tb_uart_pkt_deframer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_data [$];
    logic       q_last [$];
    int         ok_cnt  = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    logic       ov_seen = 1'b0;

    uart_pkt_deframer #(
        .SYNC_BYTE   (8'hA5),
        .MAX_LEN     (16),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (out_valid) ov_seen = 1'b1;
        if (pkt_ok)    ok_cnt++;
        if (pkt_err)   err_cnt++;
        if (overrun)   ovr_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_last.delete();
        ok_cnt  = 0;
        err_cnt = 0;
        ovr_cnt = 0;
        ov_seen = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        n_checks++;
        if (pkt_ok !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_ok: got %b expected 0", pkt_ok); end
        n_checks++;
        if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_err: got %b expected 0", pkt_err); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        resetn = 1'b1;
        tick(1);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        clear_obs();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        n_checks++;
        if (pkt_ok !== 1'b1) begin n_fail++; $display("FAIL good_pkt_ok_timing: got %b expected 1", pkt_ok); end
        tick(6);
        n_checks++;
        if (ok_cnt !== 1) begin n_fail++; $display("FAIL good_ok_count: got %0d expected 1", ok_cnt); end
        n_checks++;
        if (err_cnt !== 0) begin n_fail++; $display("FAIL good_err_count: got %0d expected 0", err_cnt); end
        n_checks++;
        if (q_data.size() !== 3) begin n_fail++; $display("FAIL good_byte_count: got %0d expected 3", q_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < q_data.size()) begin
                n_checks++;
                if (q_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL good_data[%0d]: got %h expected %h", i, q_data[i], exp_d[i]); end
                n_checks++;
                if (q_last[i] !== (i == 2)) begin n_fail++; $display("FAIL good_last[%0d]: got %b expected %b", i, q_last[i], i == 2); end
            end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_idle_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_bad_csum();
        clear_obs();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
        n_checks++;
        if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL csum_err_timing: got %b expected 1", pkt_err); end
        tick(5);
        n_checks++;
        if (err_cnt !== 1) begin n_fail++; $display("FAIL csum_err_count: got %0d expected 1", err_cnt); end
        n_checks++;
        if (ok_cnt !== 0) begin n_fail++; $display("FAIL csum_ok_count: got %0d expected 0", ok_cnt); end
        n_checks++;
        if (ov_seen !== 1'b0) begin n_fail++; $display("FAIL csum_out_valid_seen: got %b expected 0", ov_seen); end
    endtask

    task automatic test_bad_len();
        logic [7:0] bad [2] = '{8'h00, 8'h11};
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            send_byte(8'hA5);
            send_byte(bad[k]);
            n_checks++;
            if (pkt_err !== 1'b1) begin n_fail++; $display("FAIL len_%h_err: got %b expected 1", bad[k], pkt_err); end
            tick(1);
            n_checks++;
            if (pkt_err !== 1'b0) begin n_fail++; $display("FAIL len_%h_err_width: got %b expected 0", bad[k], pkt_err); end
            // Parser must be back in IDLE: a fresh frame is accepted.
            out_ready = 1'b1;
            send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEF);
            tick(3);
            n_checks++;
            if (ok_cnt !== 1 || err_cnt !== 1) begin n_fail++; $display("FAIL len_%h_recover: got ok=%0d err=%0d expected ok=1 err=1", bad[k], ok_cnt, err_cnt); end
        end
    endtask

    task automatic test_max_len();
        clear_obs();
        out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(8'h68);
        tick(20);
        n_checks++;
        if (ok_cnt !== 1) begin n_fail++; $display("FAIL maxlen_ok_count: got %0d expected 1", ok_cnt); end
        n_checks++;
        if (q_data.size() !== 16) begin n_fail++; $display("FAIL maxlen_byte_count: got %0d expected 16", q_data.size()); end
        if (q_data.size() == 16) begin
            n_checks++;
            if (q_data[15] !== 8'h10 || q_last[15] !== 1'b1 || q_last[14] !== 1'b0) begin
                n_fail++;
                $display("FAIL maxlen_tail: got %h/%b/%b expected 10/1/0", q_data[15], q_last[15], q_last[14]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_obs();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                in_data  = 8'h55;
            end
            tick(1);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h7F || out_last !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b d=%h l=%b expected v=1 d=7f l=1", i, out_valid, out_data, out_last);
            end
            n_checks++;
            if (overrun !== (i == 3)) begin n_fail++; $display("FAIL hold_overrun%0d: got %b expected %b", i, overrun, i == 3); end
        end
        // Byte arriving in the same cycle as the final handshake is also dropped.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick(1);
        in_valid = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL last_hs_overrun: got %b expected 1", overrun); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL last_hs_idle: got %b expected 0", out_valid); end
        tick(2);
        n_checks++;
        if (q_data.size() !== 1 || q_data[0] !== 8'h7F) begin n_fail++; $display("FAIL bp_delivered: got n=%0d d=%h expected n=1 d=7f", q_data.size(), q_data[0]); end
        n_checks++;
        if (ok_cnt !== 1 || ovr_cnt !== 2) begin n_fail++; $display("FAIL bp_counts: got ok=%0d ovr=%0d expected ok=1 ovr=2", ok_cnt, ovr_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        clear_obs();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
        n = 0;
        while (pkt_err !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n !== 100) begin n_fail++; $display("FAIL timeout_clocks: got %0d expected 100", n); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEF);
        tick(3);
        n_checks++;
        if (ok_cnt !== 1 || q_data.size() !== 1) begin n_fail++; $display("FAIL timeout_recover: got ok=%0d n=%0d expected ok=1 n=1", ok_cnt, q_data.size()); end
`else
        n = 150;
        tick(n);
        n_checks++;
        if (err_cnt !== 0) begin n_fail++; $display("FAIL no_timeout_err: got %0d expected 0", err_cnt); end
        send_byte(8'h55); send_byte(8'h65);
        tick(4);
        n_checks++;
        if (ok_cnt !== 1 || q_data.size() !== 2) begin n_fail++; $display("FAIL no_timeout_resume: got ok=%0d n=%0d expected ok=1 n=2", ok_cnt, q_data.size()); end
`endif
    endtask

    task automatic test_reset_mid();
        clear_obs();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        resetn = 1'b0;
        tick(1);
        n_checks++;
        if ({out_valid, out_last, pkt_ok, pkt_err, overrun, out_data} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b l=%b ok=%b err=%b ovr=%b d=%h expected all 0",
                     out_valid, out_last, pkt_ok, pkt_err, overrun, out_data);
        end
        resetn = 1'b1;
        tick(1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'hEF);
        tick(3);
        n_checks++;
        if (err_cnt !== 0) begin n_fail++; $display("FAIL midreset_no_err: got %0d expected 0", err_cnt); end
        n_checks++;
        if (ok_cnt !== 1 || q_data.size() !== 1 || q_data[0] !== 8'h10) begin
            n_fail++;
            $display("FAIL midreset_frame: got ok=%0d n=%0d d=%h expected ok=1 n=1 d=10", ok_cnt, q_data.size(), q_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_max_len();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
